i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (slave) endpoint with a 7-bit address. It is the responder counterpart of the team's I2C master.
- Synchronizes and filters SDA/SCL, detects START/STOP, matches the address, and ACKs.
- Delivers written bytes to the user side and fetches read bytes from it through a one-cycle request pulse.
- Sits between the board I2C pins and a local register file. No clock stretching: SCL is input only.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this target responds to
FILTER_LEN, 3, consecutive equal samples required before a filtered line changes (1..15)

Ports:
clk  input  1  system clock, at least 25x the SCL frequency
reset  input  1  asynchronous, active-high reset
sda  inout  1  I2C data; open-drain, driven only to 0 or Z
scl  input  1  I2C clock
rx_data  output  8  last byte written by the master
rx_valid  output  1  one-cycle pulse: rx_data updated
rx_ack  input  1  1 = ACK write data bytes, 0 = NACK; sampled at the SCL fall that ends bit 0
tx_req  output  1  one-cycle pulse: next read byte required
tx_data  input  8  read byte, captured on the clk cycle after tx_req
addressed  output  1  high from address ACK until STOP, repeated START or NACK
rw  output  1  R/W bit of the current transaction (1 = read)
busy  output  1  high between START and STOP
state  output  4  current FSM state, for debug

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; sda released (Z); FSM in IDLE; filters preset to 1.
- Input path: 2-flop synchronizer, then a FILTER_LEN glitch filter on each line.
- Edge events are single-cycle strobes derived from the filtered lines: scl_rise, scl_fall, start (SDA fall while SCL high), stop (SDA rise while SCL high).
- Sampling and driving:
  - SDA is sampled at scl_rise.
  - The slave changes its SDA drive only at scl_fall. Sync+filter latency provides the hold time.
- start from any state: enter ADDR with bit count 7, release sda, busy=1, addressed=0. A repeated START mid-byte aborts that byte with no rx_valid.
- stop from any state: enter IDLE, release sda, busy=0, addressed=0.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - ADDR: shift 8 bits MSB-first at scl_rise. At the scl_fall after bit 0:
    - on match of bits[7:1] with SLAVE_ADDR: rw=bit0, drive sda=0, go to ADDR_ACK.
    - on mismatch: go to WAIT_STOP with sda released.
  - ADDR_ACK: addressed=1 at entry.
    - If rw=1: tx_req pulses at scl_rise of the ACK clock; shift register loads tx_data the next cycle.
    - At scl_fall: if rw=0, release sda and go to WR_DATA. If rw=1, drive bit 7 of the loaded byte (0 → low, 1 → Z) and go to RD_DATA.
  - WR_DATA: shift 8 bits at scl_rise. At the 8th scl_rise: rx_data is updated and rx_valid pulses. At the following scl_fall:
    - if rx_ack=1: drive 0 and go to WR_ACK.
    - if rx_ack=0: release sda, go to WAIT_STOP, addressed=0.
  - WR_ACK: at scl_fall, release sda and return to WR_DATA with count 7.
  - RD_DATA: at each scl_fall drive the next bit. After bit 0 has been clocked out (its scl_fall), release sda and go to RD_ACK.
  - RD_ACK: sample master SDA at scl_rise.
    - If 0 (ACK): tx_req pulses, tx_data is loaded next cycle, and bit 7 is driven at scl_fall; go to RD_DATA.
    - If 1 (NACK): no tx_req; go to WAIT_STOP, addressed=0, sda released.
  - WAIT_STOP: sda released; wait for stop or start.
- Simultaneous events: start/stop take priority over scl edges in the same cycle. scl_rise and scl_fall are mutually exclusive by construction.
- Bit counter is 3 bits and wraps 0→7 only on byte completion.
- The slave never drives sda while the filtered SCL is high, except to hold an already-driven ACK or data bit.

Decomposition:
- Shared package i2c_pkg: the FSM state encoding (4-bit localparams), the ACK/NACK constants, and the R/W bit constants. The master reuses these constants.
- One sub-module, i2c_line_filter, instanced twice (SDA, SCL):
  - ports: clk, reset, async input, filtered output, rise strobe, fall strobe.
  - parameter: FILTER_LEN.
- START/STOP detection and the FSM stay in i2c_slave.

Test Plan:
- Write: START, 0xA0, 0x12 ACK, 0x34 ACK, STOP with rx_ack=1 → SDA low on all three ACK clocks; rx_valid pulses twice with rx_data 0x12 then 0x34; rw=0; busy falls after STOP.
- Read: START, 0xA1; user returns 0x5A then 0xC3; master ACKs byte 1 and NACKs byte 2 → tx_req pulses exactly twice; SDA bits read back 0x5A, 0xC3; state WAIT_STOP then IDLE.
- Address mismatch: START, 0xA2 → SDA never driven low; addressed stays 0; no rx_valid or tx_req until the next START.
- Repeated START: write 0xA0, 0x07, then Sr, 0xA1, read 1 byte with NACK, STOP → rx_valid once (0x07), then rw=1 and tx_req once.
- Filtering and NACK: 2-clk SCL glitch low during a byte with FILTER_LEN=3 → ignored, byte still correct; rx_ack=0 on a write byte → NACK, WAIT_STOP.
- Reset mid-ACK: assert reset while the slave drives ACK → sda released within the same cycle (asynchronous); all outputs 0; the next START is handled normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C constants: slave FSM state encoding, ACK/NACK levels and R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StAddr     = 4'd1,
    StAddrAck  = 4'd2,
    StWrData   = 4'd3,
    StWrAck    = 4'd4,
    StRdData   = 4'd5,
    StRdAck    = 4'd6,
    StWaitStop = 4'd7
  } state_e;

  // SDA level during the acknowledge clock.
  localparam logic Ack  = 1'b0;
  localparam logic Nack = 1'b1;

  // Bit 0 of the address byte.
  localparam logic RwWrite = 1'b0;
  localparam logic RwRead  = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// User-side data path of the I2C target: received bytes, read-byte fetch and status.
interface i2c_slave_if;
  import i2c_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       addressed;
  logic       rw;
  logic       busy;
  logic [3:0] state;

  modport slave (
    output rx_data, rx_valid, tx_req, addressed, rw, busy, state,
    input  rx_ack, tx_data
  );

  modport master (
    input  rx_data, rx_valid, tx_req, addressed, rw, busy, state,
    output rx_ack, tx_data
  );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus glitch filter for one I2C line, with registered edge strobes.
// The filtered level and its strobes change in the same cycle.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [3:0] CntMax = 4'(FILTER_LEN - 1);

  logic [1:0] sync_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  // Flip the filtered level only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = 4'd0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CntMax) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  // Lines idle high, so everything presets to 1 / no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= 4'd0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address: START/STOP detection, address match, write delivery
// and read fetch through the user interface. SCL is never stretched.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic         clk,
  input  logic         reset,
  inout  wire          sda,
  input  logic         scl,
  i2c_slave_if.slave   usr
);

  logic sda_filt, sda_rise, sda_fall;
  logic scl_filt, scl_rise, scl_fall;
  logic start_evt, stop_evt;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk    (clk),
    .reset  (reset),
    .line_i (sda),
    .filt_o (sda_filt),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk    (clk),
    .reset  (reset),
    .line_i (scl),
    .filt_o (scl_filt),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  assign start_evt = sda_fall & scl_filt;
  assign stop_evt  = sda_rise & scl_filt;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       done_q, done_d;     // byte complete (or read ACK seen), act on next scl_fall
  logic       sda_oe_q, sda_oe_d; // 1 = pull sda low
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       tx_load_q, tx_load_d;
  logic       addressed_q, addressed_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  // Next-state logic; bus conditions override any scl edge in the same cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    done_d      = done_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    tx_load_d   = tx_req_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    // User answers tx_req with tx_data, captured one cycle later.
    if (tx_load_q) shift_d = usr.tx_data;

    if (start_evt) begin
      state_d     = StAddr;
      bit_cnt_d   = 3'd7;
      done_d      = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
    end else if (stop_evt) begin
      state_d     = StIdle;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StWrData: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_filt};
            if (bit_cnt_q == 3'd0) begin
              done_d = 1'b1;
              if (state_q == StWrData) begin
                rx_data_d  = {shift_q[6:0], sda_filt};
                rx_valid_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else if (scl_fall && done_q) begin
            done_d    = 1'b0;
            bit_cnt_d = 3'd7;
            if (state_q == StAddr) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                rw_d        = shift_q[0];
                sda_oe_d    = 1'b1;
                addressed_d = 1'b1;
                state_d     = StAddrAck;
              end else begin
                state_d = StWaitStop;
              end
            end else if (usr.rx_ack) begin
              sda_oe_d = 1'b1;
              state_d  = StWrAck;
            end else begin
              addressed_d = 1'b0;
              state_d     = StWaitStop;
            end
          end
        end
        StAddrAck: begin
          if (scl_rise && rw_q == RwRead) begin
            tx_req_d = 1'b1;
          end else if (scl_fall) begin
            if (rw_q == RwWrite) begin
              sda_oe_d = 1'b0;
              state_d  = StWrData;
            end else begin
              sda_oe_d = ~shift_q[7];
              state_d  = StRdData;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StWrData;
          end
        end
        StRdData: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = StRdAck;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_filt == Ack) begin
              tx_req_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              addressed_d = 1'b0;
              state_d     = StWaitStop;
            end
          end else if (scl_fall && done_q) begin
            done_d    = 1'b0;
            sda_oe_d  = ~shift_q[7];
            bit_cnt_d = 3'd7;
            state_d   = StRdData;
          end
        end
        StWaitStop: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      done_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      tx_load_q   <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      tx_load_q   <= tx_load_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
    end
  end

  assign sda           = sda_oe_q ? 1'b0 : 1'bz;
  assign usr.rx_data   = rx_data_q;
  assign usr.rx_valid  = rx_valid_q;
  assign usr.tx_req    = tx_req_q;
  assign usr.addressed = addressed_q;
  assign usr.rw        = rw_q;
  assign usr.busy      = busy_q;
  assign usr.state     = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level I2C master, user-side model answering tx_req from a queue,
// and a monitor that scores rx_valid/tx_req against expectations queued by the stimulus.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int         Q   = 10;     // clk cycles per quarter SCL period
  localparam logic [6:0] Tgt = 7'h50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_if usr ();

  i2c_slave #(.SLAVE_ADDR(Tgt), .FILTER_LEN(3)) dut (
    .clk   (clk),
    .reset (reset),
    .sda   (sda),
    .scl   (m_scl),
    .usr   (usr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int txreq_cnt = 0;
  int slave_low_cnt = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: value 0x%0h", name, act);
  endtask

  // Scoreboard monitor: every rx_valid pops an expected byte, every tx_req pops a user byte.
  initial begin
    usr.tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (usr.rx_valid === 1'b1) begin
        rx_cnt++;
        if (exp_rx_q.size() == 0) flag("unexpected rx_valid", 32'(usr.rx_data));
        else check("rx_data", 32'(usr.rx_data), 32'(exp_rx_q.pop_front()));
      end
      if (usr.tx_req === 1'b1) begin
        txreq_cnt++;
        if (tx_q.size() == 0) flag("unexpected tx_req", 32'(txreq_cnt));
        else usr.tx_data = tx_q.pop_front();
      end
    end
  end

  // Count cycles where sda is low without the master pulling it.
  initial begin
    forever begin
      @(posedge clk);
      if (sda === 1'b0 && !m_sda_low) slave_low_cnt++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(Q);
  endtask

  // Glitch: 2-clk SCL low pulse in the middle of the high phase.
  task automatic write_bit(input logic b, input bit glitch);
    m_sda_low = ~b;
    wait_clk(Q);
    m_scl = 1'b1;
    if (glitch) begin
      wait_clk(Q);
      m_scl = 1'b0; wait_clk(2);
      m_scl = 1'b1; wait_clk(Q - 2);
    end else begin
      wait_clk(2 * Q);
    end
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    b = sda;          wait_clk(Q);
    m_scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack, 1'b0);
  endtask

  task automatic check_idle();
    check("busy after stop", 32'(usr.busy), 0);
    check("addressed after stop", 32'(usr.addressed), 0);
    check("state after stop", 32'(usr.state), 32'(StIdle));
  endtask

  // Write transaction. Model: a matching target ACKs its address, delivers every byte it
  // receives, and ACKs a data byte iff rx_ack is set; the master stops sending after a NACK.
  task automatic do_write(input logic [6:0] a, input int n, input logic [31:0] data,
                          input logic [3:0] rx_acks, input int glitch_byte,
                          input int glitch_bit, input bit do_stop);
    logic ack;
    bit   alive;
    int   rx0;
    int   tx0;
    int   pushed;
    alive  = (a == Tgt);
    rx0    = rx_cnt;
    tx0    = txreq_cnt;
    pushed = 0;
    slave_low_cnt = 0;
    i2c_start();
    check("busy after start", 32'(usr.busy), 1);
    write_byte({a, RwWrite}, -1, ack);
    check("write addr ack", 32'(ack), alive ? 32'(Ack) : 32'(Nack));
    check("addressed after addr", 32'(usr.addressed), alive ? 1 : 0);
    if (alive) check("rw write", 32'(usr.rw), 32'(RwWrite));
    for (int i = 0; i < n; i++) begin
      usr.rx_ack = rx_acks[i];
      if (alive) begin
        exp_rx_q.push_back(data[8*i +: 8]);
        pushed++;
      end
      write_byte(data[8*i +: 8], (i == glitch_byte) ? glitch_bit : -1, ack);
      check("write data ack", 32'(ack), (alive && rx_acks[i]) ? 32'(Ack) : 32'(Nack));
      if (alive && !rx_acks[i]) begin
        alive = 1'b0;
        check("state after data nack", 32'(usr.state), 32'(StWaitStop));
        check("addressed after data nack", 32'(usr.addressed), 0);
      end
      if (!alive) break;
    end
    check("rx_valid count", 32'(rx_cnt - rx0), 32'(pushed));
    check("tx_req count on write", 32'(txreq_cnt - tx0), 0);
    check("rx queue drained", 32'(exp_rx_q.size()), 0);
    if (a != Tgt) check("slave never pulled sda", 32'(slave_low_cnt), 0);
    if (do_stop) begin
      i2c_stop();
      check_idle();
    end
  endtask

  // Read transaction. Model: the master reads back exactly the bytes the user supplied,
  // one tx_req per byte, and the target waits for STOP after the final NACK.
  task automatic do_read(input logic [6:0] a, input int n, input logic [31:0] data);
    logic       ack;
    logic [7:0] got;
    bit         match;
    int         tx0;
    int         rx0;
    match = (a == Tgt);
    tx0   = txreq_cnt;
    rx0   = rx_cnt;
    slave_low_cnt = 0;
    if (match) for (int i = 0; i < n; i++) tx_q.push_back(data[8*i +: 8]);
    i2c_start();
    write_byte({a, RwRead}, -1, ack);
    check("read addr ack", 32'(ack), match ? 32'(Ack) : 32'(Nack));
    check("addressed after read addr", 32'(usr.addressed), match ? 1 : 0);
    if (match) begin
      check("rw read", 32'(usr.rw), 32'(RwRead));
      for (int i = 0; i < n; i++) begin
        read_byte(got, (i == n - 1) ? Nack : Ack);
        check("read byte", 32'(got), 32'(data[8*i +: 8]));
      end
      check("state after read nack", 32'(usr.state), 32'(StWaitStop));
      check("addressed after read nack", 32'(usr.addressed), 0);
    end else begin
      check("slave never pulled sda", 32'(slave_low_cnt), 0);
    end
    check("tx_req count", 32'(txreq_cnt - tx0), match ? 32'(n) : 0);
    check("rx_valid count on read", 32'(rx_cnt - rx0), 0);
    check("tx queue drained", 32'(tx_q.size()), 0);
    i2c_stop();
    check_idle();
  endtask

  // Reset while the target holds the address ACK low.
  task automatic reset_mid_ack();
    logic [7:0] addr_byte;
    addr_byte = {Tgt, RwWrite};
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(addr_byte[i], 1'b0);
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    check("ack driven before reset", 32'(sda), 0);
    #2;
    reset = 1'b1;
    #1;
    check("sda released by async reset", 32'(sda), 1);
    check("outputs cleared by reset",
          32'({usr.rx_data, usr.rx_valid, usr.tx_req, usr.addressed, usr.rw, usr.busy,
               usr.state}), 0);
    wait_clk(2);
    reset = 1'b0;
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  initial begin
    logic [6:0]  a;
    logic [31:0] d;
    logic [3:0]  acks;
    int          kind;
    int          n;
    usr.rx_ack = 1'b1;
    wait_clk(4);
    check("reset outputs",
          32'({usr.rx_data, usr.rx_valid, usr.tx_req, usr.addressed, usr.rw, usr.busy,
               usr.state}), 0);
    check("reset sda released", 32'(sda), 1);
    reset = 1'b0;
    wait_clk(4);

    do_write(Tgt, 2, 32'h0000_3412, 4'b0011, -1, -1, 1'b1);
    do_read(Tgt, 2, 32'h0000_C35A);
    do_write(7'h51, 1, 32'h0000_0055, 4'b0001, -1, -1, 1'b1);
    // Repeated START: write one byte, then Sr into a one-byte read.
    do_write(Tgt, 1, 32'h0000_0007, 4'b0001, -1, -1, 1'b0);
    do_read(Tgt, 1, 32'h0000_00E6);
    // SCL glitch inside byte 0, then NACK of byte 1 by the user.
    do_write(Tgt, 2, 32'h0000_9DB4, 4'b0001, 0, 3, 1'b1);
    reset_mid_ack();
    do_write(Tgt, 1, 32'h0000_00A5, 4'b0001, -1, -1, 1'b1);

    for (int it = 0; it < 12; it++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      d    = $urandom;
      a    = Tgt;
      if (kind == 3) begin
        a = 7'($urandom_range(0, 127));
        if (a == Tgt) a = a ^ 7'h01;
      end
      acks = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      if (kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1)) begin
        do_read(a, n, d);
      end else begin
        do_write(a, n, d, acks, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
